pwm_ramp_ctrl: RTL and testbench

Soft-start / soft-stop sequencer for the PWM output stage of the Tiny Tapeout user design. It owns a free-running PWM period counter and compare stage. It moves the applied duty toward a target derived from the 3-bit speed input in fixed steps, one step per PWM period. All duty changes land only on period boundaries, so no runt pulse ever reaches the pad.

---
 rtl/pwm_pkg.sv | 8 +
 rtl/pwm_core.sv | 28 ++
 rtl/pwm_ramp_ctrl.sv | 82 ++++++++
 tb/tb_pwm_ramp_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: state encoding, default counter width and speed-to-target mapping shared by the PWM ramp controller.
package pwm_pkg;
   typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} state_e;
   localparam int CNT_W_DEF = 8;
   function automatic logic [15:0] speed_target(input logic [2:0] speed, input int w);
      return 16'(speed) << (w - 3);
   endfunction
endpackage

// File: rtl/pwm_core.sv
// pwm_core: free-running period counter and registered compare; duty_i is the duty that applies from the next cycle.
module pwm_core
   import pwm_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena_i,
   input  logic [CNT_W-1:0] duty_i,
   output logic             pwm_o,
   output logic             period_end_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pwm_q;
   assign cnt_d        = ena_i ? cnt_q + 1'b1 : '0;
   assign period_end_o = &cnt_q;
   assign pwm_o        = pwm_q;
   // comparing next count with next duty keeps pwm aligned with the registered count
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt_q <= '0;
         pwm_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         pwm_q <= cnt_d < duty_i;
      end
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: soft-start/stop duty sequencer; define PWM_SOFT_STOP_EN to ramp down on stop instead of cutting at the next period end.
module pwm_ramp_ctrl
   import pwm_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int STEP  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             start,
   input  logic             stop,
   input  logic [2:0]       speed,
   output logic             pwm,
   output logic [CNT_W-1:0] duty,
   output logic             busy,
   output logic             at_target
);
`ifdef PWM_SOFT_STOP_EN
   localparam logic HARD_STOP = 1'b0;
`else
   localparam logic HARD_STOP = 1'b1;
`endif
   state_e           state_q, state_d;
   logic [CNT_W-1:0] duty_q, duty_d, target_q, target_d, goal, up_sat, dn_sat, nxt;
   logic [CNT_W:0]   up_w, dn_w;
   logic             stop_pend_q, stop_pend_d, period_end;
   assign target_d = !ena ? '0 : period_end ? CNT_W'(speed_target(speed, CNT_W)) : target_q;
   assign goal     = stop_pend_q ? '0 : target_d;
   assign up_w     = {1'b0, duty_q} + (CNT_W+1)'(STEP);
   assign dn_w     = {1'b0, duty_q} - (CNT_W+1)'(STEP);
   assign up_sat   = up_w > {1'b0, goal} ? goal : up_w[CNT_W-1:0];
   assign dn_sat   = dn_w[CNT_W] || dn_w[CNT_W-1:0] < goal ? goal : dn_w[CNT_W-1:0];
   assign nxt      = (HARD_STOP && stop_pend_q) || goal == duty_q ? goal : goal > duty_q ? up_sat : dn_sat;
   always_comb begin
      state_d     = state_q;
      duty_d      = duty_q;
      stop_pend_d = stop_pend_q;
      if (period_end && state_q != IDLE) begin
         duty_d      = nxt;
         stop_pend_d = stop_pend_q && nxt != goal;
         state_d     = nxt == goal ? (stop_pend_q ? IDLE : RUN) : goal > duty_q ? RAMP_UP : RAMP_DOWN;
      end
      if (state_q == IDLE) begin
         if (start && !stop && speed != '0) state_d = RAMP_UP;
      end else if (stop && !stop_pend_q) begin
         stop_pend_d = 1'b1;
         state_d     = HARD_STOP ? state_d : RAMP_DOWN;
      end else if (start && !stop && stop_pend_q) begin
         stop_pend_d = 1'b0;
         state_d     = RAMP_UP;
      end
      if (!ena) begin
         state_d     = IDLE;
         duty_d      = '0;
         stop_pend_d = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q     <= IDLE;
         duty_q      <= '0;
         target_q    <= '0;
         stop_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         duty_q      <= duty_d;
         target_q    <= target_d;
         stop_pend_q <= stop_pend_d;
      end
   assign duty      = duty_q;
   assign busy      = state_q == RAMP_UP || state_q == RAMP_DOWN;
   assign at_target = state_q == RUN;
   pwm_core #(.CNT_W(CNT_W)) u_core (
      .clk          (clk),
      .rst_n        (rst_n),
      .ena_i        (ena),
      .duty_i       (duty_d),
      .pwm_o        (pwm),
      .period_end_o (period_end)
   );
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed stimulus for pwm_ramp_ctrl with a per-cycle reference model of the ramp rules.
module tb_pwm_ramp_ctrl;
   localparam int W = 8, STEP = 16, PER = 256;
`ifdef PWM_SOFT_STOP_EN
   localparam bit SOFT = 1'b1;
`else
   localparam bit SOFT = 1'b0;
`endif
   logic         clk = 1'b0, rst_n = 1'b0, ena = 1'b1, start = 1'b0, stop = 1'b0;
   logic [2:0]   speed = 3'd7;
   logic         pwm, busy, at_target;
   logic [W-1:0] duty;
   int           cmp = 0, bad = 0;
   int           m_cnt, m_duty, m_mode, m_pend;
   pwm_ramp_ctrl #(.CNT_W(W), .STEP(STEP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .start     (start),
      .stop      (stop),
      .speed     (speed),
      .pwm       (pwm),
      .duty      (duty),
      .busy      (busy),
      .at_target (at_target)
   );
   always #5 clk = ~clk;
   // mode: 0 idle, 1 ramping up, 2 running, 3 ramping down
   always @(posedge clk or negedge rst_n) begin : model
      int goal, nd, nm, np, d;
      if (!rst_n || !ena) begin
         m_cnt  <= 0;
         m_duty <= 0;
         m_mode <= 0;
         m_pend <= 0;
      end else begin
         nd = m_duty;
         nm = m_mode;
         np = m_pend;
         if (m_cnt == PER - 1 && m_mode != 0) begin
            goal = m_pend != 0 ? 0 : int'(speed) * (PER / 8);
            d    = goal - m_duty;
            nd   = (m_pend != 0 && !SOFT) ? 0 : m_duty + (d > STEP ? STEP : d < -STEP ? -STEP : d);
            np   = (m_pend != 0 && nd != goal) ? 1 : 0;
            nm   = nd == goal ? (m_pend != 0 ? 0 : 2) : (goal > m_duty ? 1 : 3);
         end
         if (m_mode == 0) begin
            if (start && !stop && speed != 0) nm = 1;
         end else if (stop && m_pend == 0) begin
            np = 1;
            if (SOFT) nm = 3;
         end else if (start && !stop && m_pend != 0) begin
            np = 0;
            nm = 1;
         end
         m_cnt  <= (m_cnt + 1) % PER;
         m_duty <= nd;
         m_mode <= nm;
         m_pend <= np;
      end
   end
   task automatic check(input string name, input int act, input int exp);
      cmp++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, need %0d (t=%0t)", name, act, exp, $time);
      end
   endtask
   task automatic tick();
      @(negedge clk);
      if (rst_n) begin
         cmp++;
         if (pwm !== (m_cnt < m_duty) || duty !== W'(m_duty) || busy !== (m_mode == 1 || m_mode == 3) || at_target !== (m_mode == 2)) begin
            bad++;
            $display("FAIL cycle t=%0t: pwm=%b duty=%0d busy=%b at_target=%b, need pwm=%b duty=%0d busy=%b at_target=%b",
                     $time, pwm, duty, busy, at_target, m_cnt < m_duty, m_duty, m_mode == 1 || m_mode == 3, m_mode == 2);
         end
      end
   endtask
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   task automatic at_cnt(input int c);
      for (int i = 0; i < 2 * PER && m_cnt != c; i++) tick();
   endtask
   task automatic pulse(input bit s, input bit p);
      start = s;
      stop  = p;
      tick();
      start = 1'b0;
      stop  = 1'b0;
   endtask
   task automatic count_high(output int h);
      h = 0;
      for (int i = 0; i < PER; i++) begin
         tick();
         h += int'(pwm);
      end
   endtask
   task automatic wait_duty(input string name, input int val);
      bit ok = 1'b0;
      for (int i = 0; i < 20 * PER && !ok; i++) begin
         tick();
         ok = int'(duty) == val;
      end
      check(name, int'(ok), 1);
   endtask
   task automatic run(input string name, input bit to_idle, input int pe_exp, output int lo);
      int pe = 0;
      bit done = 1'b0;
      lo = PER;
      for (int i = 0; i < 20 * PER && !done; i++) begin
         tick();
         if (m_cnt == 0) pe++;
         if (int'(duty) < lo) lo = int'(duty);
         done = pe > 0 && (to_idle ? (!busy && !at_target) : at_target);
      end
      check({name, " done"}, int'(done), 1);
      check({name, " period ends"}, pe, pe_exp);
   endtask
   initial begin
      int h, lo;
      @(posedge clk);
      #1;
      check("reset duty", int'(duty), 0);
      check("reset pwm", int'(pwm), 0);
      check("reset busy", int'(busy), 0);
      check("reset at_target", int'(at_target), 0);
      tick();
      rst_n = 1'b1;
      ticks(3);
      check("idle after reset", int'(busy), 0);
      pulse(1'b1, 1'b1);
      ticks(PER + 10);
      check("start+stop stays idle busy", int'(busy), 0);
      check("start+stop stays idle duty", int'(duty), 0);
      speed = 3'd0;
      pulse(1'b1, 1'b0);
      count_high(h);
      check("speed0 pwm high cycles", h, 0);
      check("speed0 stays idle", int'(busy), 0);
      speed = 3'd7;
      ena   = 1'b0;
      start = 1'b1;
      ticks(2);
      start = 1'b0;
      ena   = 1'b1;
      ticks(PER);
      check("start ignored while disabled", int'(busy), 0);
      pulse(1'b1, 1'b0);
      check("soft start busy", int'(busy), 1);
      run("soft start", 1'b0, 14, lo);
      check("soft start duty", int'(duty), 224);
      count_high(h);
      check("run pwm high cycles", h, 224);
      at_cnt(10);
      speed = 3'd2;
      ticks(100);
      check("mid-period speed change duty", int'(duty), 224);
      check("mid-period speed change at_target", int'(at_target), 1);
      run("down to 64", 1'b0, 10, lo);
      check("down to 64 duty", int'(duty), 64);
      check("down to 64 minimum", lo, 64);
      speed = 3'd5;
      run("up to 160", 1'b0, 6, lo);
      check("up to 160 duty", int'(duty), 160);
      speed = 3'd7;
      run("up to 224", 1'b0, 4, lo);
      at_cnt(10);
      pulse(1'b0, 1'b1);
      run("stop", 1'b1, SOFT ? 14 : 1, lo);
      check("stop duty", int'(duty), 0);
      pulse(1'b1, 1'b0);
      run("restart", 1'b0, 14, lo);
      at_cnt(10);
      pulse(1'b0, 1'b1);
      if (SOFT) wait_duty("soft stop reaches 96", 96);
      else ticks(40);
      pulse(1'b1, 1'b0);
      run("resume", 1'b0, SOFT ? 8 : 1, lo);
      check("resume duty", int'(duty), 224);
      at_cnt(100);
      ena = 1'b0;
      tick();
      check("ena drop pwm", int'(pwm), 0);
      check("ena drop duty", int'(duty), 0);
      check("ena drop busy", int'(busy), 0);
      check("ena drop at_target", int'(at_target), 0);
      ena = 1'b1;
      pulse(1'b1, 1'b0);
      check("re-enable busy", int'(busy), 1);
      run("re-enable start", 1'b0, 14, lo);
      check("re-enable duty", int'(duty), 224);
      ena = 1'b0;
      tick();
      ena = 1'b1;
      pulse(1'b1, 1'b0);
      wait_duty("ramp reaches 80", 80);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async reset duty", int'(duty), 0);
      check("async reset pwm", int'(pwm), 0);
      check("async reset busy", int'(busy), 0);
      tick();
      rst_n = 1'b1;
      ticks(2 * PER);
      check("idle after mid-ramp reset busy", int'(busy), 0);
      check("idle after mid-ramp reset duty", int'(duty), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end
   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
